// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hard-wired control sequencer: opcodes, ALU codes,
// T-state encoding and the decoded instruction-class record.
package control_sequencer_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ALUOP_W  = 5;
  localparam int unsigned STATE_W  = 5;

  localparam logic [OPCODE_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPCODE_W-1:0] OPC_HALT = 5'b11011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 5'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 5'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_RST  = 5'd0,
    ST_T0   = 5'd1,
    ST_T1   = 5'd2,
    ST_T2   = 5'd3,
    ST_T3   = 5'd4,
    ST_T4   = 5'd5,
    ST_T5   = 5'd6,
    ST_T6   = 5'd7,
    ST_T7   = 5'd8,
    ST_HALT = 5'd9
  } state_t;

  typedef struct packed {
    logic               is_rtype;
    logic               is_imm;
    logic               is_ld;
    logic               is_st;
    logic               is_br;
    logic               is_halt;
    logic               is_illegal;
    logic [ALUOP_W-1:0] alu_op;
  } instr_class_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Opcode classifier: maps IR[31:27] to an instruction class and ALU operation.
module instr_class_decode
  import control_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls
);

  always_comb begin
    cls        = '0;
    cls.alu_op = ALU_ADD;
    case (opcode)
      OPC_ADD:  cls.is_rtype = 1'b1;
      OPC_SUB:  begin cls.is_rtype = 1'b1; cls.alu_op = ALU_SUB; end
      OPC_AND:  begin cls.is_rtype = 1'b1; cls.alu_op = ALU_AND; end
      OPC_OR:   begin cls.is_rtype = 1'b1; cls.alu_op = ALU_OR;  end
      OPC_ADDI: cls.is_imm = 1'b1;
      OPC_ANDI: begin cls.is_imm = 1'b1; cls.alu_op = ALU_AND; end
      OPC_ORI:  begin cls.is_imm = 1'b1; cls.alu_op = ALU_OR;  end
      OPC_LD:   cls.is_ld   = 1'b1;
      OPC_ST:   cls.is_st   = 1'b1;
      OPC_BR:   cls.is_br   = 1'b1;
      OPC_HALT: cls.is_halt = 1'b1;
      default:  cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: fetch, decode and T-state sequencing of the
// data_path strobes, with mem_ready stalls on Read/Write states and HALT.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic               Clock,
  input  logic               clear,
  input  logic [31:0]        ir,
  input  logic               branchCompare,
  input  logic               mem_ready,
  output logic               PCout,
  output logic               Zhighout,
  output logic               Zlowout,
  output logic               MDRout,
  output logic               Cout,
  output logic               PCin,
  output logic               IRin,
  output logic               MARin,
  output logic               MDRin,
  output logic               Yin,
  output logic               ZHighin,
  output logic               Zlowin,
  output logic               CONin,
  output logic               IncPC,
  output logic               Read,
  output logic               Write,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAOut,
  output logic [ALUOP_W-1:0] op,
  output logic               run,
  output logic               illegal_op
);

  state_t       state, state_nxt;
  instr_class_t cls;
  logic         addr_calc;
  logic         unused_ir;

  assign unused_ir = ^ir[31-OPCODE_W:0];

  instr_class_decode u_decode (
    .opcode (ir[31:32-OPCODE_W]),
    .cls    (cls)
  );

  // ld/st share the immediate-style effective-address computation in T3-T4
  assign addr_calc = cls.is_imm | cls.is_ld | cls.is_st;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = mem_ready ? ST_T2 : ST_T1;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        if (cls.is_halt)         state_nxt = ST_HALT;
        else if (cls.is_illegal) state_nxt = ST_T0;
        else                     state_nxt = ST_T4;
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5:   state_nxt = (cls.is_rtype | cls.is_imm) ? ST_T0 : ST_T6;
      ST_T6: begin
        if (cls.is_br)      state_nxt = ST_T0;
        else if (cls.is_ld) state_nxt = mem_ready ? ST_T7 : ST_T6;
        else                state_nxt = ST_T7;
      end
      ST_T7:   state_nxt = (cls.is_st && !mem_ready) ? ST_T7 : ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    ZHighin = 1'b0; Zlowin = 1'b0; CONin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAOut = 1'b0;
    op = '0;
    illegal_op = 1'b0;
    run = (state != ST_RST) && (state != ST_HALT);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (cls.is_rtype) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (addr_calc)    begin Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; end
        if (cls.is_br)    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        illegal_op = cls.is_illegal;
      end
      ST_T4: begin
        if (cls.is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; op = cls.alu_op; ZHighin = 1'b1; Zlowin = 1'b1;
        end
        if (addr_calc) begin
          Cout = 1'b1; op = cls.alu_op; ZHighin = 1'b1; Zlowin = 1'b1;
        end
        if (cls.is_br) begin PCout = 1'b1; Yin = 1'b1; end
      end
      ST_T5: begin
        if (cls.is_rtype | cls.is_imm) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (cls.is_ld | cls.is_st)     begin Zlowout = 1'b1; MARin = 1'b1; end
        if (cls.is_br) begin
          Cout = 1'b1; op = cls.alu_op; ZHighin = 1'b1; Zlowin = 1'b1;
        end
      end
      ST_T6: begin
        if (cls.is_ld) begin Read = 1'b1; MDRin = 1'b1; end
        if (cls.is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        // branchCompare is the data_path CON register, stable since T3
        if (cls.is_br) begin Zlowout = 1'b1; PCin = branchCompare; end
      end
      ST_T7: begin
        if (cls.is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (cls.is_st) begin MDRout = 1'b1; Write = 1'b1; end
      end
      default: ;
    endcase
  end

  a_one_bus_source: assert property (@(posedge Clock) disable iff (!clear)
    $onehot0({PCout, Zhighout, Zlowout, MDRout, Cout, Rout, BAOut}));

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: per-cycle expected strobe
// vectors come from a step-table model of each instruction class.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear, branchCompare, mem_ready;
  logic [31:0] ir;
  logic PCout, Zhighout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin;
  logic ZHighin, Zlowin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAOut;
  logic [4:0] op;
  logic run, illegal_op;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .ir(ir), .branchCompare(branchCompare),
    .mem_ready(mem_ready), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .Cout(Cout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAOut(BAOut), .op(op), .run(run), .illegal_op(illegal_op)
  );

  always #5 Clock = ~Clock;

  localparam logic [28:0] M_PCOUT = 29'h1 << 28, M_ZHOUT = 29'h1 << 27, M_ZLOUT = 29'h1 << 26;
  localparam logic [28:0] M_MDROUT = 29'h1 << 25, M_COUT = 29'h1 << 24, M_PCIN = 29'h1 << 23;
  localparam logic [28:0] M_IRIN = 29'h1 << 22, M_MARIN = 29'h1 << 21, M_MDRIN = 29'h1 << 20;
  localparam logic [28:0] M_YIN = 29'h1 << 19, M_ZHIN = 29'h1 << 18, M_ZLIN = 29'h1 << 17;
  localparam logic [28:0] M_CONIN = 29'h1 << 16, M_INCPC = 29'h1 << 15, M_READ = 29'h1 << 14;
  localparam logic [28:0] M_WRITE = 29'h1 << 13, M_GRA = 29'h1 << 12, M_GRB = 29'h1 << 11;
  localparam logic [28:0] M_GRC = 29'h1 << 10, M_RIN = 29'h1 << 9, M_ROUT = 29'h1 << 8;
  localparam logic [28:0] M_BAOUT = 29'h1 << 7, M_RUN = 29'h1 << 1, M_ILL = 29'h1;

  localparam logic [4:0] O_LD = 5'b00000, O_ST = 5'b00010, O_ADD = 5'b00011, O_SUB = 5'b00100;
  localparam logic [4:0] O_AND = 5'b00101, O_OR = 5'b00110, O_ADDI = 5'b01100;
  localparam logic [4:0] O_ANDI = 5'b01101, O_ORI = 5'b01110, O_BR = 5'b10010, O_HALT = 5'b11011;

  typedef struct {
    logic        clr;
    logic        mr;
    logic        bc;
    logic [31:0] irv;
    logic [28:0] exp;
  } item_t;

  item_t       drv_q[$];
  logic [28:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  function automatic logic [28:0] alu_field(input logic [4:0] o);
    logic [4:0] a;
    case (o)
      O_SUB:         a = 5'd1;
      O_AND, O_ANDI: a = 5'd2;
      O_OR, O_ORI:   a = 5'd3;
      default:       a = 5'd0;
    endcase
    return 29'(a) << 2;
  endfunction

  function automatic bit is_legal(input logic [4:0] o);
    return o inside {O_LD, O_ST, O_ADD, O_SUB, O_AND, O_OR, O_ADDI, O_ANDI, O_ORI, O_BR, O_HALT};
  endfunction

  task automatic push(input logic c, input logic m, input logic b, input logic [31:0] i,
                      input logic [28:0] e);
    item_t it;
    it.clr = c; it.mr = m; it.bc = b; it.irv = i; it.exp = e;
    drv_q.push_back(it);
  endtask

  task automatic push_reset();
    push(1'b0, 1'($urandom), 1'($urandom), $urandom, '0);
    push(1'b1, 1'($urandom), 1'($urandom), $urandom, '0);
  endtask

  // fw/ew: stall cycles on the fetch read and on the execute memory step (<0 = random)
  task automatic gen_instr(input logic [31:0] iv, input logic bc, input int abort_at,
                           input int fw, input int ew);
    logic [28:0] steps[$];
    logic [4:0]  o;
    logic [28:0] alu;
    logic [28:0] s;
    logic        bcv;
    int          w;
    o   = iv[31:27];
    alu = alu_field(o);
    steps.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZHIN | M_ZLIN);
    steps.push_back(M_ZLOUT | M_PCIN | M_READ | M_MDRIN);
    steps.push_back(M_MDROUT | M_IRIN);
    if (o inside {O_ADD, O_SUB, O_AND, O_OR}) begin
      steps.push_back(M_GRB | M_ROUT | M_YIN);
      steps.push_back(M_GRC | M_ROUT | alu | M_ZHIN | M_ZLIN);
      steps.push_back(M_ZLOUT | M_GRA | M_RIN);
    end else if (o inside {O_ADDI, O_ANDI, O_ORI, O_LD, O_ST}) begin
      steps.push_back(M_GRB | M_BAOUT | M_YIN);
      steps.push_back(M_COUT | alu | M_ZHIN | M_ZLIN);
      if (o == O_LD) begin
        steps.push_back(M_ZLOUT | M_MARIN);
        steps.push_back(M_READ | M_MDRIN);
        steps.push_back(M_MDROUT | M_GRA | M_RIN);
      end else if (o == O_ST) begin
        steps.push_back(M_ZLOUT | M_MARIN);
        steps.push_back(M_GRA | M_ROUT | M_MDRIN);
        steps.push_back(M_MDROUT | M_WRITE);
      end else begin
        steps.push_back(M_ZLOUT | M_GRA | M_RIN);
      end
    end else if (o == O_BR) begin
      steps.push_back(M_GRA | M_ROUT | M_CONIN);
      steps.push_back(M_PCOUT | M_YIN);
      steps.push_back(M_COUT | M_ZHIN | M_ZLIN);
      steps.push_back(M_ZLOUT | (bc ? M_PCIN : 29'h0));
    end else if (o == O_HALT) begin
      steps.push_back('0);
    end else begin
      steps.push_back(M_ILL);
    end
    foreach (steps[i]) begin
      s = steps[i] | M_RUN;
      bcv = (o == O_BR) ? bc : 1'($urandom);
      if (i == abort_at) begin
        push(1'b0, 1'($urandom), bcv, iv, '0);
        push(1'b1, 1'($urandom), 1'($urandom), $urandom, '0);
        return;
      end
      if ((s & (M_READ | M_WRITE)) != 0) begin
        w = (i == 1) ? fw : ew;
        if (w < 0) w = int'($urandom_range(0, 3));
        repeat (w) push(1'b1, 1'b0, bcv, iv, s);
        push(1'b1, 1'b1, bcv, iv, s);
      end else begin
        push(1'b1, 1'($urandom), bcv, iv, s);
      end
    end
    if (o == O_HALT) begin
      repeat (20) push(1'b1, 1'($urandom), 1'($urandom), $urandom, '0);
      push_reset();
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] o);
    return {o, 27'($urandom)};
  endfunction

  // Driver: applies one item per cycle just after the edge and posts its expectation
  initial begin
    item_t it;
    clear = 1'b0; mem_ready = 1'b0; branchCompare = 1'b0; ir = '0;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (drv_q.size() > 0) begin
        it = drv_q.pop_front();
        clear = it.clr; mem_ready = it.mr; branchCompare = it.bc; ir = it.irv;
        exp_q.push_back(it.exp);
      end
    end
  end

  // Monitor: the sequencer presents a control word every cycle
  initial begin
    logic [28:0] e, a;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {PCout, Zhighout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin,
             ZHighin, Zlowin, CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAOut,
             op, run, illegal_op};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL ctrl_word cyc=%0d ir=%h got=%h exp=%h", cyc, ir, a, e);
        end
      end
    end
  end

  initial begin
    logic [4:0] legal[10];
    logic [4:0] o;
    legal = '{O_LD, O_ST, O_ADD, O_SUB, O_AND, O_OR, O_ADDI, O_ANDI, O_ORI, O_BR};

    push(1'b0, 1'b1, 1'b0, '0, '0);
    push_reset();
    gen_instr(32'h61A00035, 1'b0, -1, 0, 0);
    gen_instr(mk(O_LD), 1'b0, -1, 0, 3);
    gen_instr(mk(O_BR), 1'b1, -1, 0, 0);
    gen_instr(mk(O_BR), 1'b0, -1, 0, 0);
    gen_instr(mk(O_ADD), 1'b0, -1, -1, -1);
    gen_instr(32'hF8000000 | 32'($urandom_range(0, 32'h07FFFFFF)), 1'b0, -1, 0, 0);
    gen_instr(mk(O_ST), 1'b0, -1, 2, 2);
    gen_instr(mk(O_SUB), 1'b0, 4, 0, 0);
    gen_instr(mk(O_ORI), 1'b0, -1, -1, -1);
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 5'($urandom); while (is_legal(o));
      end else begin
        o = legal[$urandom_range(0, 9)];
      end
      gen_instr(mk(o), 1'($urandom), ($urandom_range(0, 15) == 0) ? 3 + int'($urandom_range(0, 2)) : -1,
                -1, -1);
    end
    gen_instr(mk(O_HALT), 1'b0, -1, -1, -1);
    gen_instr(mk(O_ANDI), 1'b0, -1, 0, 0);

    while ((drv_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) @(posedge Clock);
    if (drv_q.size() > 0 || exp_q.size() > 0) begin
      failures++;
      $display("FAIL timeout pending_drv=%0d pending_exp=%0d required=0", drv_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
